// File: rtl/p2s_sched.sv
// p2s_sched
//   Round-robin scheduler and sequencer in front of a shared parallel-to-serial
//   converter. Two sources offer DWI-bit words; one word at a time is granted,
//   loaded into the serializer with p2s_wen, then stepped out with p2s_ren as
//   NBEAT = DWI/DWO narrow beats on a valid/ready stream. Each beat carries
//   the index of its source, and the final beat of a word is marked.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   reqN_valid/data/ready     source N word offer / word / accepted this cycle
//   p2s_wen, p2s_ren, p2s_din serializer load strobe, shift strobe, load data
//   p2s_dout                  serializer current low beat
//   out_valid/data/last/src   beat stream (data = p2s_dout), last beat, source
//   out_ready                 downstream accepts the beat
//   busy                      a word is in flight
module p2s_sched #(
  parameter int DWI = 224,
  parameter int DWO = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [DWI-1:0] req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [DWI-1:0] req1_data,
  output logic           req1_ready,
  output logic           p2s_wen,
  output logic           p2s_ren,
  output logic [DWI-1:0] p2s_din,
  input  logic [DWO-1:0] p2s_dout,
  output logic           out_valid,
  output logic [DWO-1:0] out_data,
  output logic           out_last,
  output logic           out_src,
  input  logic           out_ready,
  output logic           busy
);

  localparam int NBEAT = DWI / DWO;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  if ((DWI % DWO) != 0 || NBEAT < 2) begin : g_bad_param
    $error("p2s_sched: DWI must be a multiple of DWO with at least two beats");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            src_q, src_d;
  logic            last_grant_q, last_grant_d;

  logic            hs;
  logic            last_beat;
  logic            gw;
  logic            grant_any;
  logic            grant_sel;

  always_comb begin
    busy      = (state_q == SEND);
    last_beat = busy && (cnt_q == CW'(NBEAT - 1));
    hs        = busy && out_ready;

    out_valid = busy;
    out_last  = last_beat;
    out_src   = busy ? src_q : 1'b0;
    out_data  = busy ? p2s_dout : '0;

    // A new word may be granted when idle, or exactly when the final beat
    // of the current word is taken, which gives bubble-free back-to-back words.
    gw        = !busy || (hs && last_beat);
    grant_any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req1_valid;
    end

    req0_ready = gw && grant_any && !grant_sel;
    req1_ready = gw && grant_any &&  grant_sel;
    p2s_wen    = gw && grant_any;
    p2s_din    = p2s_wen ? (grant_sel ? req1_data : req0_data) : '0;
    // Never shift on the last beat: that cycle is either a reload or idle.
    p2s_ren    = hs && !last_beat;

    state_d      = state_q;
    cnt_d        = cnt_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (p2s_wen) begin
      state_d      = SEND;
      cnt_d        = '0;
      src_d        = grant_sel;
      last_grant_d = grant_sel;
    end else if (p2s_ren) begin
      cnt_d = cnt_q + CW'(1);
    end else if (hs && last_beat) begin
      state_d = IDLE;
    end
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: doc/p2s_sched.md
# p2s_sched

Round-robin scheduler and sequencer for the shared parallel-to-serial converter (`par2ser`) at the accelerator output. Two upstream sources each present DWI-bit result words. The block grants one word at a time and loads it into the serializer with `wen`. It then steps the serializer with `ren` so that DWI/DWO narrow beats go out on a valid/ready stream, each beat tagged with its source and with the last beat marked.

## Interface
- `DWI`, 224, wide word width; must be an integer multiple of `DWO`.
- `DWO`, 32, beat width.
- Derived localparam `NBEAT` = DWI/DWO; must be at least 2.
- Beat-counter width is $clog2(NBEAT).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  source 0 has a word.
- `req0_data`  in  DWI  source 0 word.
- `req0_ready`  out  1  source 0 word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`  same as the three source 0 ports, for source 1.
- `p2s_wen`  out  1  serializer load strobe.
- `p2s_ren`  out  1  serializer shift strobe.
- `p2s_din`  out  DWI  serializer load data.
- `p2s_dout`  in  DWO  serializer current low beat.
- `out_valid`  out  1  beat available.
- `out_data`  out  DWO  beat; equals `p2s_dout`.
- `out_last`  out  1  final beat of a word.
- `out_src`  out  1  source index of the word in flight.
- `out_ready`  in  1  downstream accepts the beat.
- `busy`  out  1  a word is in flight.

## Operation
- Serializer contract:
  - The cycle after `p2s_wen`, `p2s_dout` = din[DWO-1:0].
  - Each `p2s_ren` advances it by one beat, so beat k = din[k*DWO +: DWO].
  - `wen` has priority over `ren`.
- FSM states: IDLE and SEND. Registers:
  - `cnt`, the beat counter.
  - `src`, the source of the word in flight.
  - `last_grant`.
- Grant window `gw`:
  - asserted when the state is IDLE;
  - asserted in SEND when `out_valid`, `out_ready` and `out_last` are all 1;
  - deasserted otherwise.
- Arbitration:
  - Only one source valid: grant that source.
  - Both valid: grant the source opposite to `last_grant`.
  - Neither valid: no grant.
  - `reqN_ready` = gw AND the grant selects N. It is combinational and may depend on `out_ready`.
- On a grant:
  - `p2s_wen`=1 and `p2s_din` = the granted data, same cycle.
  - Next state SEND, `cnt`<=0, `src`<=N, `last_grant`<=N.
- SEND:
  - `out_valid`=1, `out_data`=`p2s_dout`, `out_src`=`src`, `out_last`=(`cnt`==NBEAT-1).
  - Handshake on a beat that is not last: `p2s_ren`=1 and `cnt`<=`cnt`+1.
  - Handshake on the last beat with a grant: `p2s_wen`=1 and `p2s_ren`=0. Stay in SEND with `cnt`<=0 (back-to-back).
  - Handshake on the last beat with no grant: next state IDLE, no strobe.
  - `out_ready`=0: all outputs hold; no strobes; `cnt` holds.
- IDLE: `out_valid`=0, `out_last`=0.
- `busy` = (state==SEND).
- `p2s_wen` and `p2s_ren` are never both 1.

## Timing
- Reset values:
  - state IDLE, `cnt`=0, `src`=0, `last_grant`=1, so source 0 wins the first contention.
  - All outputs 0, and `p2s_din`=0 while there is no grant.
- Latency: a word accepted in cycle T (ready and valid both 1) produces its first beat with `out_valid`=1 in cycle T+1.
- Throughput with `out_ready` held at 1:
  - back-to-back words give NBEAT beats per NBEAT cycles with no bubble;
  - a word arriving while IDLE costs one idle cycle.
- Every word emits exactly NBEAT beats, in order beat 0 to beat NBEAT-1. `out_last` is 1 only on beat NBEAT-1.
- Request holding: a source whose valid is held never waits more than one word from the other source.
- `rst` mid-word:
  - the FSM returns to IDLE in the next cycle;
  - the remaining beats are dropped;
  - there is no further `out_valid` until a new grant;
  - stale serializer contents are never emitted, because the next `wen` reloads.
- A request that deasserts before being granted is ignored.

## Test plan
- **Single word.** Reset, then hold `req0_valid` for one accepted word with `out_ready`=1. Require:
  - `req0_ready` and `p2s_wen` in cycle T;
  - 7 beats in cycles T+1..T+7, with `out_last` only at T+7;
  - `out_src`=0;
  - `p2s_ren` in cycles T+1..T+6;
  - then IDLE and `busy`=0.
- **Contention and round-robin.** Both sources continuously valid, `out_ready`=1. Require:
  - grants in the order 0,1,0,1;
  - 28 contiguous beats with no bubble;
  - `p2s_wen` on each last-beat cycle and never together with `p2s_ren`.
- **Backpressure.** Toggle `out_ready` 1010... during a word. Require:
  - `out_data`, `out_last` and `out_src` stable while `out_ready`=0;
  - `p2s_ren` only on handshake cycles;
  - exactly 7 beats delivered, equal to din[32k+:32] for k=0..6.
- **Late second request.** `req1_valid` rises in the cycle of source 0's last beat. Require:
  - the grant happens in that same cycle (`req1_ready`=1);
  - the first beat of source 1 follows in the next cycle.
- **Reset mid-word.** Assert `rst` after beat 3. Require:
  - `out_valid`=0 and `busy`=0 in the next cycle;
  - `last_grant` back to 1;
  - a following contention grants source 0 first.
